// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: button-driven time-setting controller for the watch datapath.
// Captures the running time into edit registers when set mode is entered. The
// user selects a field and adjusts it with wrap-around. The edit is committed
// atomically through one-cycle set strobes, or abandoned after an idle timeout.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_btn_mode/next/up/down   one-cycle button pulses (priority mode>next>up>down)
//   i_hour, i_min, i_sec      running time from the datapath
//   o_set_mode_active         high while editing or committing
//   o_{hour,min,sec}_set      one-cycle commit strobes
//   o_{hour,min,sec}_value    edit registers
//   o_sel_field               00 none, 01 hour, 10 min, 11 sec
//   o_blink                   blink phase for the selected field
module watch_set_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000,
  parameter int unsigned BLINK_CYC   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_next,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  output logic       o_set_mode_active,
  output logic       o_hour_set,
  output logic [4:0] o_hour_value,
  output logic       o_min_set,
  output logic [5:0] o_min_value,
  output logic       o_sec_set,
  output logic [5:0] o_sec_value,
  output logic [1:0] o_sel_field,
  output logic       o_blink
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned BL_W = $clog2(BLINK_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOUR,
    S_MIN,
    S_SEC,
    S_COMMIT
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      hour_q, hour_nxt;
  logic [5:0]      min_q, min_nxt;
  logic [5:0]      sec_q, sec_nxt;
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic [BL_W-1:0] bl_cnt, bl_nxt;
  logic            blink_q, blink_nxt;
  logic            active_q, active_nxt;
  logic            commit_q, commit_nxt;
  logic [1:0]      sel_q, sel_nxt;
  logic            any_btn;
  logic            in_set, nxt_in_set;

  // Wrap-around step; anything at or above the limit (incl. out-of-range) goes to 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] lim);
    return (v >= lim) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] lim);
    return (v == 6'd0) ? lim : v - 6'd1;
  endfunction

  assign any_btn    = i_btn_mode | i_btn_next | i_btn_up | i_btn_down;
  assign in_set     = (state == S_HOUR) || (state == S_MIN) || (state == S_SEC);
  assign nxt_in_set = (state_nxt == S_HOUR) || (state_nxt == S_MIN) || (state_nxt == S_SEC);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      to_cnt   <= '0;
      bl_cnt   <= '0;
      blink_q  <= 1'b0;
      active_q <= 1'b0;
      commit_q <= 1'b0;
      sel_q    <= 2'b00;
    end else begin
      state    <= state_nxt;
      hour_q   <= hour_nxt;
      min_q    <= min_nxt;
      sec_q    <= sec_nxt;
      to_cnt   <= to_nxt;
      bl_cnt   <= bl_nxt;
      blink_q  <= blink_nxt;
      active_q <= active_nxt;
      commit_q <= commit_nxt;
      sel_q    <= sel_nxt;
    end
  end

  // Next-state, edit, timeout, blink and output decode.
  always_comb begin
    state_nxt  = state;
    hour_nxt   = hour_q;
    min_nxt    = min_q;
    sec_nxt    = sec_q;
    to_nxt     = '0;
    bl_nxt     = '0;
    blink_nxt  = 1'b0;
    active_nxt = 1'b0;
    commit_nxt = 1'b0;
    sel_nxt    = 2'b00;

    case (state)
      S_IDLE: begin
        if (i_btn_mode) begin
          state_nxt = S_HOUR;
          hour_nxt  = i_hour;
          min_nxt   = i_min;
          sec_nxt   = i_sec;
        end
      end
      S_HOUR, S_MIN, S_SEC: begin
        if (i_btn_mode) begin
          state_nxt = S_COMMIT;
        end else if (i_btn_next) begin
          state_nxt = (state == S_HOUR) ? S_MIN : (state == S_MIN) ? S_SEC : S_HOUR;
        end else if (i_btn_up) begin
          if (state == S_HOUR)     hour_nxt = 5'(wrap_inc({1'b0, hour_q}, 6'd23));
          else if (state == S_MIN) min_nxt  = wrap_inc(min_q, 6'd59);
          else                     sec_nxt  = wrap_inc(sec_q, 6'd59);
        end else if (i_btn_down) begin
          if (state == S_HOUR)     hour_nxt = 5'(wrap_dec({1'b0, hour_q}, 6'd23));
          else if (state == S_MIN) min_nxt  = wrap_dec(min_q, 6'd59);
          else                     sec_nxt  = wrap_dec(sec_q, 6'd59);
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Blink restarts "on" at entry and on every press so the edited field stays visible.
    // Outside the SET states (IDLE, COMMIT) the blink phase is held low.
    if (nxt_in_set) begin
      if (!in_set || any_btn) begin
        blink_nxt = 1'b1;
      end else if (bl_cnt == BL_LAST) begin
        blink_nxt = ~blink_q;
      end else begin
        blink_nxt = blink_q;
        bl_nxt    = bl_cnt + BL_W'(1);
      end
    end

    active_nxt = (state_nxt != S_IDLE);
    commit_nxt = (state_nxt == S_COMMIT);
    case (state_nxt)
      S_HOUR:  sel_nxt = 2'b01;
      S_MIN:   sel_nxt = 2'b10;
      S_SEC:   sel_nxt = 2'b11;
      default: sel_nxt = 2'b00;
    endcase
  end

  assign o_set_mode_active = active_q;
  assign o_hour_set        = commit_q;
  assign o_min_set         = commit_q;
  assign o_sec_set         = commit_q;
  assign o_hour_value      = hour_q;
  assign o_min_value       = min_q;
  assign o_sec_value       = sec_q;
  assign o_sel_field       = sel_q;
  assign o_blink           = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: self-checking bench for watch_set_ctrl with a behavioural
// reference model (mode/field index, integer edit values, quiet-cycle count).
module tb_watch_set_ctrl;

  localparam int TO = 20;
  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bm = 1'b0, bn = 1'b0, bu = 1'b0, bd = 1'b0;
  logic [4:0] ih = '0;
  logic [5:0] im = '0, is = '0;

  logic       act, hs, ms, ss, blk;
  logic [4:0] hv;
  logic [5:0] mnv, sv;
  logic [1:0] sel;

  watch_set_ctrl #(.TIMEOUT_CYC(TO), .BLINK_CYC(BL)) dut (
    .clk(clk), .rst(rst),
    .i_btn_mode(bm), .i_btn_next(bn), .i_btn_up(bu), .i_btn_down(bd),
    .i_hour(ih), .i_min(im), .i_sec(is),
    .o_set_mode_active(act),
    .o_hour_set(hs), .o_hour_value(hv),
    .o_min_set(ms), .o_min_value(mnv),
    .o_sec_set(ss), .o_sec_value(sv),
    .o_sel_field(sel), .o_blink(blk)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: mstate 0 idle, 1 hour, 2 min, 3 sec, 4 commit.
  int mstate = 0;
  int quiet = 0;
  int mv[3] = '{0, 0, 0};

  logic [23:0] obs, expv, msk;
  assign obs = {act, sel, hs, ms, ss, hv, mnv, sv, blk};

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_MODE = 4'b1000;
  localparam logic [3:0] B_NEXT = 4'b0100;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0001;

  function automatic int inc_w(input int v, input int lim);
    return (v >= lim) ? 0 : v + 1;
  endfunction

  function automatic int dec_w(input int v, input int lim);
    return (v == 0) ? lim : v - 1;
  endfunction

  // Expected output vector from the model state.
  function automatic logic [23:0] exp_vec();
    logic a, s, b;
    logic [1:0] f;
    a = (mstate != 0);
    s = (mstate == 4);
    f = (mstate >= 1 && mstate <= 3) ? 2'(mstate) : 2'd0;
    b = (mstate >= 1 && mstate <= 3) ? (((quiet / BL) % 2) == 0) : 1'b0;
    return {a, f, s, s, s, 5'(mv[0]), 6'(mv[1]), 6'(mv[2]), b};
  endfunction

  // Blink is only defined in IDLE and the SET states.
  function automatic logic [23:0] exp_mask();
    return (mstate == 4) ? 24'hFF_FFFE : 24'hFF_FFFF;
  endfunction

  task automatic model_edge();
    int lim;
    if (rst) begin
      mstate = 0; quiet = 0; mv = '{0, 0, 0};
      return;
    end
    case (mstate)
      0: if (bm) begin
        mv = '{int'(ih), int'(im), int'(is)};
        mstate = 1; quiet = 0;
      end
      1, 2, 3: begin
        lim = (mstate == 1) ? 23 : 59;
        if (bm | bn | bu | bd) begin
          quiet = 0;
          if (bm)      mstate = 4;
          else if (bn) mstate = (mstate % 3) + 1;
          else if (bu) mv[mstate-1] = inc_w(mv[mstate-1], lim);
          else         mv[mstate-1] = dec_w(mv[mstate-1], lim);
        end else if (quiet == TO - 1) begin
          mstate = 0; quiet = 0;
        end else begin
          quiet++;
        end
      end
      default: mstate = 0;
    endcase
  endtask

  // Drive one cycle of stimulus, advance the model, settle past the edge.
  task automatic cyc(input logic r, input logic [3:0] b);
    rst = r;
    {bm, bn, bu, bd} = b;
    @(posedge clk);
    model_edge();
    #1;
    expv = exp_vec();
    msk  = exp_mask();
  endtask

  task automatic test_reset();
    cyc(1'b1, B_NONE);
    vectors++;
    if (obs !== 24'h0) begin
      miscompares++;
      $display("FAIL reset: got %h, expected %h", obs, 24'h0);
    end
    cyc(1'b0, B_NONE);
    vectors++;
    if ((obs & msk) !== (expv & msk)) begin
      miscompares++;
      $display("FAIL reset_idle: got %h, expected %h", obs, expv);
    end
  endtask

  task automatic test_entry();
    ih = 5'd13; im = 6'd45; is = 6'd7;
    cyc(1'b0, B_MODE);
    vectors++;
    if ({act, sel, hv, mnv, sv, blk, hs | ms | ss} !== {1'b1, 2'b01, 5'd13, 6'd45, 6'd7, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL entry: got act=%b sel=%b %0d/%0d/%0d blink=%b stb=%b, expected 1 01 13/45/7 1 0",
               act, sel, hv, mnv, sv, blk, hs | ms | ss);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] q[$];
    repeat (11) q.push_back(B_UP);    // 13 -> 23 -> 0
    q.push_back(B_NEXT);
    repeat (15) q.push_back(B_UP);    // 45 -> 59 -> 0
    q.push_back(B_DOWN);              // 0 -> 59
    q.push_back(B_NEXT);
    repeat (53) q.push_back(B_UP);    // 7 -> 59 -> 0
    q.push_back(B_NEXT);
    foreach (q[i]) begin
      cyc(1'b0, q[i]);
      vectors++;
      if ((obs & msk) !== (expv & msk)) begin
        miscompares++;
        $display("FAIL wrap step %0d: got %h, expected %h", i, obs, expv);
      end
    end
    vectors++;
    if ({sel, hv, mnv, sv} !== {2'b01, 5'd0, 6'd59, 6'd0}) begin
      miscompares++;
      $display("FAIL wrap_final: got sel=%b %0d/%0d/%0d, expected 01 0/59/0", sel, hv, mnv, sv);
    end
    cyc(1'b0, B_MODE);
    cyc(1'b0, B_NONE);
  endtask

  task automatic test_commit();
    ih = 5'd5; im = 6'd30; is = 6'd15;
    cyc(1'b0, B_MODE);
    cyc(1'b0, B_MODE);
    vectors++;
    if ({act, sel, hs, ms, ss, hv, mnv, sv} !== {1'b1, 2'b00, 3'b111, 5'd5, 6'd30, 6'd15}) begin
      miscompares++;
      $display("FAIL commit: got act=%b sel=%b stb=%b%b%b %0d/%0d/%0d, expected 1 00 111 5/30/15",
               act, sel, hs, ms, ss, hv, mnv, sv);
    end
    cyc(1'b0, B_NONE);
    vectors++;
    if ({act, hs, ms, ss, sel} !== 5'b0) begin
      miscompares++;
      $display("FAIL commit_after: got act=%b stb=%b%b%b sel=%b, expected all 0", act, hs, ms, ss, sel);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] pat;
    logic stb_seen;
    pat = 8'b1111_0000;
    stb_seen = 1'b0;
    // Abort after TO cycles, checking the blink waveform on the way.
    cyc(1'b0, B_MODE);
    for (int k = 0; k < TO; k++) begin
      if (k > 0) cyc(1'b0, B_NONE);
      stb_seen = stb_seen | hs | ms | ss;
      if (k < 8) begin
        vectors++;
        if (blk !== pat[7-k]) begin
          miscompares++;
          $display("FAIL blink k=%0d: got %b, expected %b", k, blk, pat[7-k]);
        end
      end
      vectors++;
      if ((obs & msk) !== (expv & msk)) begin
        miscompares++;
        $display("FAIL timeout_model k=%0d: got %h, expected %h", k, obs, expv);
      end
    end
    vectors++;
    if (act !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got active=%b, expected 1", act);
    end
    cyc(1'b0, B_NONE);
    stb_seen = stb_seen | hs | ms | ss;
    vectors++;
    if ({act, sel, blk, stb_seen} !== 5'b0) begin
      miscompares++;
      $display("FAIL timeout_abort: got act=%b sel=%b blink=%b strobe_seen=%b, expected 0", act, sel, blk, stb_seen);
    end
    // A press on the terminal cycle keeps the edit alive.
    cyc(1'b0, B_MODE);
    repeat (TO - 1) cyc(1'b0, B_NONE);
    cyc(1'b0, B_UP);
    vectors++;
    if ({act, sel, blk} !== 4'b1011) begin
      miscompares++;
      $display("FAIL timeout_saved: got act=%b sel=%b blink=%b, expected 1 01 1", act, sel, blk);
    end
    repeat (TO - 1) cyc(1'b0, B_NONE);
    vectors++;
    if (act !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_restart: got active=%b, expected 1", act);
    end
    cyc(1'b0, B_NONE);
    vectors++;
    if ((obs & msk) !== (expv & msk) || act !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort2: got %h, expected %h", obs, expv);
    end
  endtask

  task automatic test_priority();
    ih = 5'd10; im = 6'd20; is = 6'd30;
    cyc(1'b0, B_MODE);
    cyc(1'b0, B_NEXT);
    cyc(1'b0, B_MODE | B_UP);
    vectors++;
    if ({hs, ms, ss, mnv} !== {3'b111, 6'd20}) begin
      miscompares++;
      $display("FAIL prio_mode_up: got stb=%b%b%b min=%0d, expected 111 20", hs, ms, ss, mnv);
    end
    cyc(1'b0, B_NONE);
    cyc(1'b0, B_MODE);
    cyc(1'b0, B_UP | B_DOWN);
    vectors++;
    if ({sel, hv} !== {2'b01, 5'd11}) begin
      miscompares++;
      $display("FAIL prio_up_down: got sel=%b hour=%0d, expected 01 11", sel, hv);
    end
    cyc(1'b0, B_NEXT | B_UP);
    vectors++;
    if ({sel, hv, mnv} !== {2'b10, 5'd11, 6'd20}) begin
      miscompares++;
      $display("FAIL prio_next_up: got sel=%b %0d/%0d, expected 10 11/20", sel, hv, mnv);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, B_NEXT);
    vectors++;
    if (sel !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_mid_setup: got sel=%b, expected 11", sel);
    end
    cyc(1'b1, B_UP);
    vectors++;
    if (obs !== 24'h0) begin
      miscompares++;
      $display("FAIL rst_mid: got %h, expected %h", obs, 24'h0);
    end
    cyc(1'b0, B_NONE);
    vectors++;
    if (obs !== 24'h0) begin
      miscompares++;
      $display("FAIL rst_mid_after: got %h, expected %h", obs, 24'h0);
    end
  endtask

  task automatic test_out_of_range();
    ih = 5'd31; im = 6'd63; is = 6'd60;
    cyc(1'b0, B_MODE);
    vectors++;
    if ({hv, mnv, sv} !== {5'd31, 6'd63, 6'd60}) begin
      miscompares++;
      $display("FAIL oor_load: got %0d/%0d/%0d, expected 31/63/60", hv, mnv, sv);
    end
    cyc(1'b0, B_UP);
    cyc(1'b0, B_NEXT);
    cyc(1'b0, B_DOWN);
    cyc(1'b0, B_NEXT);
    cyc(1'b0, B_UP);
    vectors++;
    if ({hv, mnv, sv} !== {5'd0, 6'd62, 6'd0}) begin
      miscompares++;
      $display("FAIL oor_edit: got %0d/%0d/%0d, expected 0/62/0", hv, mnv, sv);
    end
    cyc(1'b1, B_NONE);
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic r;
    for (int n = 0; n < 1500; n++) begin
      ih = 5'($urandom_range(0, 31));
      im = 6'($urandom_range(0, 63));
      is = 6'($urandom_range(0, 63));
      b  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : B_NONE;
      r  = ($urandom_range(0, 399) == 0);
      cyc(r, b);
      vectors++;
      if ((obs & msk) !== (expv & msk)) begin
        miscompares++;
        $display("FAIL random n=%0d: got %h, expected %h", n, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_wrap();
    test_commit();
    test_timeout();
    test_priority();
    test_reset_mid();
    test_out_of_range();
    test_random();
    cyc(1'b0, B_NONE);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
